// File: rtl/alu_issue_stage.sv
// Issue stage in front of a single-cycle MIPS-style ALU: decodes one instruction,
// reads operands from a 32x32 register file, hands them to the ALU and writes the result back.
module alu_issue_stage #(
    parameter int          NREG   = 32,
    parameter logic [5:0]  BEQ_OP = 6'b000100,
    parameter logic [5:0]  BNE_OP = 6'b000101
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic [31:0] INSTR,
    output logic        ISSUE_VALID,
    input  logic        ISSUE_READY,
    output logic [5:0]  OPCODE,
    output logic [31:0] RS_VAL,
    output logic [31:0] RT_VAL,
    output logic [4:0]  SHAMT,
    output logic [5:0]  FUNC,
    output logic [15:0] RAW_VAL,
    input  logic [31:0] RESULT,
    input  logic        SIG_B,
    input  logic        RESULT_VALID,
    output logic        WB_VALID,
    output logic [4:0]  WB_ADDR,
    output logic [31:0] WB_DATA,
    output logic        BRANCH_TAKEN,
    input  logic        LOAD_EN,
    input  logic [4:0]  LOAD_ADDR,
    input  logic [31:0] LOAD_DATA
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_regs [NREG];
    logic [4:0]  r_dest;
    logic        r_branch;

    logic [4:0]  w_rs_addr;
    logic [4:0]  w_rt_addr;
    logic [4:0]  w_dest;
    logic        w_is_branch;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;

    // Decode of the offered word; register 0 is forced to read as zero.
    always_comb begin
        w_rs_addr   = INSTR[25:21];
        w_rt_addr   = INSTR[20:16];
        w_dest      = (INSTR[31:26] == 6'd0) ? INSTR[15:11] : INSTR[20:16];
        w_is_branch = (INSTR[31:26] == BEQ_OP) || (INSTR[31:26] == BNE_OP);
        w_rs_val    = (w_rs_addr == 5'd0) ? 32'd0 : r_regs[w_rs_addr];
        w_rt_val    = (w_rt_addr == 5'd0) ? 32'd0 : r_regs[w_rt_addr];
    end

    // Control FSM, register file and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_dest       <= 5'd0;
            r_branch     <= 1'b0;
            INSTR_READY  <= 1'b1;
            ISSUE_VALID  <= 1'b0;
            OPCODE       <= 6'd0;
            RS_VAL       <= 32'd0;
            RT_VAL       <= 32'd0;
            SHAMT        <= 5'd0;
            FUNC         <= 6'd0;
            RAW_VAL      <= 16'd0;
            WB_VALID     <= 1'b0;
            WB_ADDR      <= 5'd0;
            WB_DATA      <= 32'd0;
            BRANCH_TAKEN <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            WB_VALID     <= 1'b0;
            BRANCH_TAKEN <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (INSTR_VALID) begin
                        OPCODE      <= INSTR[31:26];
                        SHAMT       <= INSTR[10:6];
                        FUNC        <= INSTR[5:0];
                        RAW_VAL     <= INSTR[15:0];
                        RS_VAL      <= w_rs_val;
                        RT_VAL      <= w_rt_val;
                        r_dest      <= w_dest;
                        r_branch    <= w_is_branch;
                        ISSUE_VALID <= 1'b1;
                        INSTR_READY <= 1'b0;
                        r_state     <= S_ISSUE;
                    end else if (LOAD_EN && (LOAD_ADDR != 5'd0)) begin
                        r_regs[LOAD_ADDR] <= LOAD_DATA;
                    end else begin
                        INSTR_READY <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (ISSUE_READY) begin
                        ISSUE_VALID <= 1'b0;
                        r_state     <= S_WAIT_RES;
                    end else begin
                        ISSUE_VALID <= 1'b1;
                    end
                end
                S_WAIT_RES: begin
                    if (RESULT_VALID) begin
                        r_state     <= S_IDLE;
                        INSTR_READY <= 1'b1;
                        if (r_branch) begin
                            BRANCH_TAKEN <= SIG_B;
                        end else if (r_dest != 5'd0) begin
                            r_regs[r_dest] <= RESULT;
                            WB_VALID       <= 1'b1;
                            WB_ADDR        <= r_dest;
                            WB_DATA        <= RESULT;
                        end else begin
                            WB_VALID <= 1'b0;
                        end
                    end else begin
                        r_state <= S_WAIT_RES;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    INSTR_READY <= 1'b1;
                    ISSUE_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vector table, hand-written reset/backpressure
// sequences and random instructions checked against an array-based register model.
module tb_alu_issue_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INSTR_VALID = 1'b0;
    logic        INSTR_READY;
    logic [31:0] INSTR = 32'd0;
    logic        ISSUE_VALID;
    logic        ISSUE_READY = 1'b0;
    logic [5:0]  OPCODE;
    logic [31:0] RS_VAL;
    logic [31:0] RT_VAL;
    logic [4:0]  SHAMT;
    logic [5:0]  FUNC;
    logic [15:0] RAW_VAL;
    logic [31:0] RESULT = 32'd0;
    logic        SIG_B = 1'b0;
    logic        RESULT_VALID = 1'b0;
    logic        WB_VALID;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        BRANCH_TAKEN;
    logic        LOAD_EN = 1'b0;
    logic [4:0]  LOAD_ADDR = 5'd0;
    logic [31:0] LOAD_DATA = 32'd0;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [32];

    alu_issue_stage dut (
        .CLK(CLK), .RST(RST), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .INSTR(INSTR), .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
        .OPCODE(OPCODE), .RS_VAL(RS_VAL), .RT_VAL(RT_VAL), .SHAMT(SHAMT), .FUNC(FUNC),
        .RAW_VAL(RAW_VAL), .RESULT(RESULT), .SIG_B(SIG_B), .RESULT_VALID(RESULT_VALID),
        .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .BRANCH_TAKEN(BRANCH_TAKEN), .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR),
        .LOAD_DATA(LOAD_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] result;
        logic        sig_b;
        int          stall;
        logic        exp_wb;
        logic [4:0]  exp_addr;
        logic        exp_br;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [4:0] addr, input logic [31:0] data);
        LOAD_EN = 1'b1; LOAD_ADDR = addr; LOAD_DATA = data;
        step();
        LOAD_EN = 1'b0;
        chk("load_no_wb", {31'd0, WB_VALID}, 32'd0);
        if (addr != 5'd0) model[addr] = data;
    endtask

    // Full instruction lifecycle; operand expectations come from the model array.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] result,
                             input logic sig_b, input int stall, input logic exp_wb,
                             input logic [4:0] exp_addr, input logic exp_br);
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        e_rs = model[instr[25:21]];
        e_rt = model[instr[20:16]];
        chk("instr_ready_idle", {31'd0, INSTR_READY}, 32'd1);
        INSTR_VALID = 1'b1; INSTR = instr;
        LOAD_EN = 1'b1; LOAD_ADDR = 5'd7; LOAD_DATA = 32'hBAD0_0007;
        step();
        INSTR_VALID = 1'b0; LOAD_EN = 1'b0;
        for (int c = 0; c <= stall; c++) begin
            chk("issue_valid", {31'd0, ISSUE_VALID}, 32'd1);
            chk("instr_ready_busy", {31'd0, INSTR_READY}, 32'd0);
            chk("opcode", {26'd0, OPCODE}, {26'd0, instr[31:26]});
            chk("rs_val", RS_VAL, e_rs);
            chk("rt_val", RT_VAL, e_rt);
            chk("shamt", {27'd0, SHAMT}, {27'd0, instr[10:6]});
            chk("func", {26'd0, FUNC}, {26'd0, instr[5:0]});
            chk("raw_val", {16'd0, RAW_VAL}, {16'd0, instr[15:0]});
            chk("no_wb_issue", {31'd0, WB_VALID}, 32'd0);
            if (c < stall) begin
                INSTR_VALID = 1'b1; INSTR = ~instr;
                LOAD_EN = 1'b1; LOAD_ADDR = 5'd7; LOAD_DATA = 32'hBAD1_0007;
                RESULT_VALID = 1'b1; RESULT = 32'hFFFF_0000;
                step();
                INSTR_VALID = 1'b0; LOAD_EN = 1'b0; RESULT_VALID = 1'b0;
            end
        end
        ISSUE_READY = 1'b1;
        step();
        ISSUE_READY = 1'b0;
        chk("issue_valid_drop", {31'd0, ISSUE_VALID}, 32'd0);
        step();
        chk("wait_no_wb", {31'd0, WB_VALID}, 32'd0);
        chk("wait_ready_low", {31'd0, INSTR_READY}, 32'd0);
        RESULT_VALID = 1'b1; RESULT = result; SIG_B = sig_b;
        step();
        RESULT_VALID = 1'b0; SIG_B = 1'b0;
        chk("wb_valid", {31'd0, WB_VALID}, {31'd0, exp_wb});
        if (exp_wb) begin
            chk("wb_addr", {27'd0, WB_ADDR}, {27'd0, exp_addr});
            chk("wb_data", WB_DATA, result);
            model[exp_addr] = result;
        end
        chk("branch_taken", {31'd0, BRANCH_TAKEN}, {31'd0, exp_br});
        chk("done_ready", {31'd0, INSTR_READY}, 32'd1);
        step();
        chk("wb_pulse_end", {31'd0, WB_VALID}, 32'd0);
        chk("br_pulse_end", {31'd0, BRANCH_TAKEN}, 32'd0);
        chk("no_stray_issue", {31'd0, ISSUE_VALID}, 32'd0);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [5:0]  op;
        logic [4:0]  dst;
        logic        br;
        logic [31:0] res;
        logic        sb;

        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        //           instr         result        sigb  stall wb    addr   br
        vecs[0] = '{32'h0022_1843, 32'd6,         1'b0, 0, 1'b1, 5'd3, 1'b0};
        vecs[1] = '{32'h0022_1820, 32'd27,        1'b0, 5, 1'b1, 5'd3, 1'b0};
        vecs[2] = '{32'h2024_FFFF, 32'd14,        1'b0, 0, 1'b1, 5'd4, 1'b0};
        vecs[3] = '{32'h0024_2820, 32'd29,        1'b0, 1, 1'b1, 5'd5, 1'b0};
        vecs[4] = '{32'h1022_0005, 32'd0,         1'b1, 0, 1'b0, 5'd0, 1'b1};
        vecs[5] = '{32'h1022_0005, 32'd1,         1'b0, 0, 1'b0, 5'd0, 1'b0};
        vecs[6] = '{32'h1422_0005, 32'd0,         1'b1, 2, 1'b0, 5'd0, 1'b1};
        vecs[7] = '{32'h0022_0020, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 5'd0, 1'b0};
        vecs[8] = '{32'h0001_0820, 32'd1,         1'b0, 0, 1'b1, 5'd1, 1'b0};
        vecs[9] = '{32'h00E7_4020, 32'd77,        1'b0, 0, 1'b1, 5'd8, 1'b0};

        step(); step();
        RST = 1'b0;
        chk("rst_instr_ready", {31'd0, INSTR_READY}, 32'd1);
        chk("rst_issue_valid", {31'd0, ISSUE_VALID}, 32'd0);
        chk("rst_wb_valid", {31'd0, WB_VALID}, 32'd0);
        chk("rst_branch", {31'd0, BRANCH_TAKEN}, 32'd0);
        chk("rst_rs_val", RS_VAL, 32'd0);
        chk("rst_wb_data", WB_DATA, 32'd0);

        do_load(5'd1, 32'd15);
        do_load(5'd2, 32'd12);
        do_load(5'd0, 32'h1234_5678);
        for (int v = 0; v < 10; v++) begin
            run_instr(vecs[v].instr, vecs[v].result, vecs[v].sig_b, vecs[v].stall,
                      vecs[v].exp_wb, vecs[v].exp_addr, vecs[v].exp_br);
        end

        // Reset while waiting for the result abandons the instruction.
        INSTR_VALID = 1'b1; INSTR = 32'h0022_1820;
        step();
        INSTR_VALID = 1'b0; ISSUE_READY = 1'b1;
        step();
        ISSUE_READY = 1'b0;
        RST = 1'b1; RESULT_VALID = 1'b1; RESULT = 32'h55;
        step();
        RST = 1'b0;
        chk("rstw_no_wb", {31'd0, WB_VALID}, 32'd0);
        chk("rstw_ready", {31'd0, INSTR_READY}, 32'd1);
        chk("rstw_issue", {31'd0, ISSUE_VALID}, 32'd0);
        step();
        RESULT_VALID = 1'b0;
        chk("rstw_late_rv", {31'd0, WB_VALID}, 32'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        run_instr(32'h0022_1820, 32'd9, 1'b0, 0, 1'b1, 5'd3, 1'b0);
        run_instr(32'h0083_2820, 32'd4, 1'b0, 0, 1'b1, 5'd5, 1'b0);

        // Random instructions against the register model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) do_load(5'($urandom_range(0, 31)), $urandom);
            rnd = $urandom;
            case ($urandom_range(0, 3))
                0: op = 6'd0;
                1: op = 6'b000100;
                2: op = 6'b000101;
                default: op = rnd[31:26];
            endcase
            rnd = {op, rnd[25:0]};
            dst = (op == 6'd0) ? rnd[15:11] : rnd[20:16];
            br  = (op == 6'b000100) || (op == 6'b000101);
            res = $urandom;
            sb  = 1'($urandom_range(0, 1));
            run_instr(rnd, res, sb, $urandom_range(0, 3), !br && (dst != 5'd0), dst, br && sb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Sequential front end that drives the single-cycle ALU (ports OPCODE, RS_VAL, RT_VAL, SHAMT, FUNC, RAW_VAL) and consumes its outputs (RESULT, SIG_B).
- Accepts 32-bit MIPS-format instruction words, decodes the fields and reads operands from an internal 32x32 register file.
- Issues one operand bundle at a time over a valid/ready handshake, then writes the returned RESULT back into the register file.
- Sits between instruction fetch and the ALU. It is the producer of exactly the stimulus the ALU expects.

Parameters:
- NREG, 32, number of architectural registers (register 0 is hardwired to zero).
- BEQ_OP, 6'b000100, opcode treated as a branch (no writeback, SIG_B captured).
- BNE_OP, 6'b000101, second branch opcode (same handling as BEQ_OP).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- INSTR_VALID  in  1  an instruction word is offered.
- INSTR_READY  out  1  the stage can accept an instruction.
- INSTR  in  32  instruction word.
- ISSUE_VALID  out  1  the operand bundle below is valid.
- ISSUE_READY  in  1  the ALU side accepts the bundle.
- OPCODE  out  6  INSTR[31:26].
- RS_VAL  out  32  register file value of INSTR[25:21].
- RT_VAL  out  32  register file value of INSTR[20:16].
- SHAMT  out  5  INSTR[10:6].
- FUNC  out  6  INSTR[5:0].
- RAW_VAL  out  16  INSTR[15:0].
- RESULT  in  32  ALU result.
- SIG_B  in  1  ALU branch condition.
- RESULT_VALID  in  1  RESULT and SIG_B are valid this cycle.
- WB_VALID  out  1  one-cycle pulse when the register file is written.
- WB_ADDR  out  5  register being written.
- WB_DATA  out  32  value being written.
- BRANCH_TAKEN  out  1  one-cycle pulse for a branch that returned SIG_B=1.
- LOAD_EN  in  1  preload write enable.
- LOAD_ADDR  in  5  preload address.
- LOAD_DATA  in  32  preload data.

Behaviour:
- Reset (RST=1 at a rising edge):
  - State goes to IDLE.
  - All 32 registers are cleared to 0.
  - All outputs go to 0, except INSTR_READY, which is 1 once in IDLE.
  - Reset mid-operation abandons any in-flight instruction: no WB_VALID, no BRANCH_TAKEN.
- FSM states: IDLE, ISSUE, WAIT_RES.
- IDLE:
  - INSTR_READY=1.
  - On INSTR_VALID, the instruction is accepted in that cycle. The stage registers OPCODE, SHAMT, FUNC, RAW_VAL, the destination and the branch flag, and samples RS_VAL/RT_VAL from the register file, then moves to ISSUE.
  - Destination is INSTR[15:11] when the opcode is 0, else INSTR[20:16].
- ISSUE:
  - ISSUE_VALID=1 from the cycle after acceptance (latency 1).
  - The bundle is held stable until ISSUE_READY=1. On that edge the stage goes to WAIT_RES.
  - INSTR_READY=0.
- WAIT_RES:
  - The first cycle with RESULT_VALID=1 completes the instruction.
  - Non-branch with destination not 0: write RESULT into the register file, and pulse WB_VALID for one cycle with WB_ADDR/WB_DATA.
  - Destination 0: no write and no WB_VALID.
  - Branch opcode: no write; BRANCH_TAKEN=SIG_B for one cycle.
  - Return to IDLE. A new instruction can be accepted in the following cycle.
- RESULT_VALID outside WAIT_RES is ignored.
- Only one instruction is in flight, so no RAW hazard exists: a following instruction always reads the written-back value.
- Register 0 always reads 0, and writes to it (writeback or LOAD) are discarded.
- LOAD port:
  - Honoured only in IDLE when INSTR_VALID=0; ignored otherwise.
  - Does not pulse WB_VALID.
- Operand outputs retain their last values when ISSUE_VALID=0.

Test Plan:
- SRA issue: LOAD r1=15, r2=12; INSTR=0x00221843 -> next cycle ISSUE_VALID=1 with OPCODE=0, RS_VAL=15, RT_VAL=12, SHAMT=1, FUNC=3; with ISSUE_READY=1 and RESULT_VALID with RESULT=6 -> WB_VALID, WB_ADDR=3, WB_DATA=6.
- Backpressure: ISSUE_READY held 0 for 5 cycles -> bundle stays unchanged, INSTR_READY=0, a second INSTR_VALID is not accepted.
- I-type and chained read: INSTR=0x2024FFFF (addi, rs=1, rt=4) -> RAW_VAL=0xFFFF; RESULT=14 -> r4=14. The next instruction reading r4 sees RT_VAL=14.
- Branch: INSTR=0x10220005 with SIG_B=1 at RESULT_VALID -> BRANCH_TAKEN pulse, WB_VALID=0. The same test with SIG_B=0 -> no pulse.
- Destination zero: R-type with rd=0 and RESULT=0xDEADBEEF -> no WB_VALID; a later read of r0 returns 0.
- Reset in WAIT_RES: assert RST, then drive RESULT_VALID -> no writeback, all registers 0, INSTR_READY=1 after reset.
